minibit_alu: RTL and testbench

MINIBIT_ALU -- requirements
Module: minibit_alu

---
 rtl/minibit_alu.sv | 254 +++++++++++++++++++++++++
 tb/tb_minibit_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/minibit_alu.sv
// Minimal 8-bit ALU: opcode decoder, combinational datapath and three registered flags.
// The decoder reads only the registered carry, so ADC/SBB never form a combinational loop.

module minibit_alu_decoder (
  input  logic [7:0] bus,
  input  logic       fl_carry,
  output logic       a_pass,
  output logic       a_lt,
  output logic       a_rt,
  output logic       b_en,
  output logic       b_inv,
  output logic       o_add,
  output logic       o_nand,
  output logic       carry_add,
  output logic       carry_bit
);

  typedef enum logic [2:0] {
    OpPass = 3'b000,
    OpAdd  = 3'b001,
    OpNand = 3'b010,
    OpSub  = 3'b011,
    OpShl  = 3'b100,
    OpAdc  = 3'b101,
    OpShr  = 3'b110,
    OpSbb  = 3'b111
  } op_e;

  op_e op;

  // Low five bits of the instruction byte carry no meaning here.
  assign op = op_e'(bus[7:5]);

  always_comb begin
    a_pass    = 1'b0;
    a_lt      = 1'b0;
    a_rt      = 1'b0;
    b_en      = 1'b0;
    b_inv     = 1'b0;
    o_add     = 1'b0;
    o_nand    = 1'b0;
    carry_add = 1'b0;
    carry_bit = 1'b0;
    unique case (op)
      OpPass: begin
        a_pass = 1'b1;
        o_add  = 1'b1;
      end
      OpAdd: begin
        a_pass = 1'b1;
        b_en   = 1'b1;
        o_add  = 1'b1;
      end
      OpAdc: begin
        a_pass    = 1'b1;
        b_en      = 1'b1;
        o_add     = 1'b1;
        carry_add = 1'b1;
        carry_bit = fl_carry;
      end
      OpSub: begin
        a_pass    = 1'b1;
        b_en      = 1'b1;
        b_inv     = 1'b1;
        o_add     = 1'b1;
        carry_bit = 1'b1;
      end
      OpSbb: begin
        a_pass    = 1'b1;
        b_en      = 1'b1;
        b_inv     = 1'b1;
        o_add     = 1'b1;
        carry_add = 1'b1;
        carry_bit = fl_carry;
      end
      OpNand: begin
        a_pass = 1'b1;
        b_en   = 1'b1;
        o_nand = 1'b1;
      end
      OpShl: begin
        a_lt  = 1'b1;
        o_add = 1'b1;
      end
      OpShr: begin
        a_rt  = 1'b1;
        o_add = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

module minibit_alu_datapath (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       a_pass,
  input  logic       a_lt,
  input  logic       a_rt,
  input  logic       b_en,
  input  logic       b_inv,
  input  logic       o_add,
  input  logic       o_nand,
  input  logic       carry_bit,
  output logic [7:0] o,
  output logic       pre_carry,
  output logic       pre_lt,
  output logic       pre_z
);

  logic [7:0] a_op;
  logic [7:0] b_op;
  logic [8:0] sum;

  always_comb begin
    a_op = 8'h00;
    if (a_pass) begin
      a_op = a;
    end else if (a_lt) begin
      a_op = {a[6:0], 1'b0};
    end else if (a_rt) begin
      a_op = {1'b0, a[7:1]};
    end
  end

  always_comb begin
    b_op = 8'h00;
    if (b_en) begin
      b_op = b_inv ? ~b : b;
    end
  end

  assign sum = {1'b0, a_op} + {1'b0, b_op} + {8'h00, carry_bit};

  always_comb begin
    o = 8'h00;
    if (o_add) begin
      o = sum[7:0];
    end else if (o_nand) begin
      o = ~(a_op & b_op);
    end
  end

  // Shifts report the bit shifted out; for SUB/SBB a set carry means no borrow.
  always_comb begin
    pre_carry = sum[8];
    if (o_nand) begin
      pre_carry = 1'b0;
    end else if (a_lt) begin
      pre_carry = a[7];
    end else if (a_rt) begin
      pre_carry = a[0];
    end
  end

  assign pre_lt = (a < b);
  assign pre_z  = (o == 8'h00);

endmodule

module minibit_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       flag_we,
  output logic [7:0] o,
  output logic       pre_carry,
  output logic       pre_lt,
  output logic       pre_z,
  output logic       fl_carry,
  output logic       fl_lt,
  output logic       fl_z
);

  logic a_pass;
  logic a_lt;
  logic a_rt;
  logic b_en;
  logic b_inv;
  logic o_add;
  logic o_nand;
  logic carry_add;
  logic carry_bit;

  logic fl_carry_d, fl_carry_q;
  logic fl_lt_d, fl_lt_q;
  logic fl_z_d, fl_z_q;

  minibit_alu_decoder u_decoder (
    .bus       (bus),
    .fl_carry  (fl_carry_q),
    .a_pass    (a_pass),
    .a_lt      (a_lt),
    .a_rt      (a_rt),
    .b_en      (b_en),
    .b_inv     (b_inv),
    .o_add     (o_add),
    .o_nand    (o_nand),
    .carry_add (carry_add),
    .carry_bit (carry_bit)
  );

  minibit_alu_datapath u_datapath (
    .a         (a),
    .b         (b),
    .a_pass    (a_pass),
    .a_lt      (a_lt),
    .a_rt      (a_rt),
    .b_en      (b_en),
    .b_inv     (b_inv),
    .o_add     (o_add),
    .o_nand    (o_nand),
    .carry_bit (carry_bit),
    .o         (o),
    .pre_carry (pre_carry),
    .pre_lt    (pre_lt),
    .pre_z     (pre_z)
  );

  // carry_add is informational only; the carry value itself arrives on carry_bit.
  logic unused_carry_add;
  assign unused_carry_add = carry_add;

  always_comb begin
    fl_carry_d = fl_carry_q;
    fl_lt_d    = fl_lt_q;
    fl_z_d     = fl_z_q;
    if (flag_we) begin
      fl_carry_d = pre_carry;
      fl_lt_d    = pre_lt;
      fl_z_d     = pre_z;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_carry_q <= 1'b0;
      fl_lt_q    <= 1'b0;
      fl_z_q     <= 1'b0;
    end else begin
      fl_carry_q <= fl_carry_d;
      fl_lt_q    <= fl_lt_d;
      fl_z_q     <= fl_z_d;
    end
  end

  assign fl_carry = fl_carry_q;
  assign fl_lt    = fl_lt_q;
  assign fl_z     = fl_z_q;

endmodule

// File: tb/tb_minibit_alu.sv
// Directed-vector bench for minibit_alu with hand-computed expectations.

module tb_minibit_alu;

  logic       clk;
  logic       rst;
  logic [7:0] bus;
  logic [7:0] a;
  logic [7:0] b;
  logic       flag_we;
  logic [7:0] o;
  logic       pre_carry;
  logic       pre_lt;
  logic       pre_z;
  logic       fl_carry;
  logic       fl_lt;
  logic       fl_z;

  int unsigned n_cmp;
  int unsigned n_bad;

  minibit_alu dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .a         (a),
    .b         (b),
    .flag_we   (flag_we),
    .o         (o),
    .pre_carry (pre_carry),
    .pre_lt    (pre_lt),
    .pre_z     (pre_z),
    .fl_carry  (fl_carry),
    .fl_lt     (fl_lt),
    .fl_z      (fl_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change mid-cycle; outputs are sampled 1 time unit later.
  task automatic drive(input logic [7:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic we);
    bus     = op;
    a       = av;
    b       = bv;
    flag_we = we;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus     = 8'h00;
    a       = 8'h00;
    b       = 8'h00;
    flag_we = 1'b0;

    // Reset, with combinational path still live during reset.
    @(negedge clk);
    drive(8'h20, 8'h04, 8'h04, 1'b1);
    check("rst_comb_o", o, 8'h08);
    tick();
    check("rst_fl_carry", {7'd0, fl_carry}, 8'h00);
    check("rst_fl_lt", {7'd0, fl_lt}, 8'h00);
    check("rst_fl_z", {7'd0, fl_z}, 8'h00);
    rst = 1'b0;

    // ADD 4+4
    @(negedge clk);
    drive(8'h20, 8'h04, 8'h04, 1'b0);
    check("add_o", o, 8'h08);
    check("add_carry", {7'd0, pre_carry}, 8'h00);
    check("add_z", {7'd0, pre_z}, 8'h00);
    check("add_lt", {7'd0, pre_lt}, 8'h00);

    // Low instruction bits are ignored.
    drive(8'h3F, 8'h04, 8'h04, 1'b0);
    check("add_junk_o", o, 8'h08);

    // SUB 9-2, latch flags
    drive(8'h60, 8'h09, 8'h02, 1'b1);
    check("sub_o", o, 8'h07);
    check("sub_carry", {7'd0, pre_carry}, 8'h01);
    tick();
    check("sub_fl_carry", {7'd0, fl_carry}, 8'h01);
    check("sub_fl_lt", {7'd0, fl_lt}, 8'h00);

    // ADC uses registered carry; flags hold with flag_we low.
    @(negedge clk);
    drive(8'hA0, 8'h04, 8'h04, 1'b0);
    check("adc_o", o, 8'h09);
    tick();
    check("hold_fl_carry", {7'd0, fl_carry}, 8'h01);

    // SBB 9-2 with carry set = 9-2 (no borrow in)
    @(negedge clk);
    drive(8'hE0, 8'h09, 8'h02, 1'b0);
    check("sbb_o", o, 8'h07);

    // Reset overrides flag_we; following ADC sees carry 0.
    drive(8'h60, 8'h09, 8'h02, 1'b1);
    rst = 1'b1;
    tick();
    check("rst2_fl_carry", {7'd0, fl_carry}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    drive(8'hA0, 8'h04, 8'h04, 1'b0);
    check("adc_after_rst_o", o, 8'h08);

    // SUB sweep a=9, b=15..0
    for (int i = 15; i >= 0; i--) begin
      logic [7:0] bv;
      logic [8:0] full;
      bv = 8'(i);
      drive(8'h60, 8'h09, bv, 1'b0);
      full = 9'd9 + {1'b0, ~bv} + 9'd1;
      check("sweep_o", o, full[7:0]);
    end
    drive(8'h60, 8'h09, 8'h0F, 1'b0);
    check("sub15_o", o, 8'hFA);
    check("sub15_carry", {7'd0, pre_carry}, 8'h00);
    check("sub15_lt", {7'd0, pre_lt}, 8'h01);
    drive(8'h60, 8'h09, 8'h09, 1'b1);
    check("sub9_o", o, 8'h00);
    check("sub9_z", {7'd0, pre_z}, 8'h01);
    check("sub9_carry", {7'd0, pre_carry}, 8'h01);
    tick();
    check("sub9_fl_z", {7'd0, fl_z}, 8'h01);
    @(negedge clk);
    drive(8'h60, 8'h09, 8'h00, 1'b0);
    check("sub0_o", o, 8'h09);

    // Latch fl_lt from an op with a<b
    drive(8'h20, 8'h01, 8'h02, 1'b1);
    tick();
    check("add_fl_lt", {7'd0, fl_lt}, 8'h01);
    check("add_fl_z", {7'd0, fl_z}, 8'h00);

    // Shifts and NAND on a=0x81
    @(negedge clk);
    drive(8'h80, 8'h81, 8'h00, 1'b0);
    check("shl_o", o, 8'h02);
    check("shl_carry", {7'd0, pre_carry}, 8'h01);
    drive(8'hC0, 8'h81, 8'h00, 1'b0);
    check("shr_o", o, 8'h40);
    check("shr_carry", {7'd0, pre_carry}, 8'h01);
    drive(8'h40, 8'h81, 8'hFF, 1'b0);
    check("nand_o", o, 8'h7E);
    check("nand_carry", {7'd0, pre_carry}, 8'h00);
    drive(8'h00, 8'h5A, 8'hFF, 1'b0);
    check("pass_o", o, 8'h5A);
    check("pass_lt", {7'd0, pre_lt}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
